// File: rtl/user_softreg_responder_pkg.sv
// Shared types for the user soft-register responder.
//   ShellTypes   : soft-register request/response structs used by the shell.
//   UserRegTypes : control-register offsets (relative to the first control slot,
//                  which sits right after the NUM_CFG config registers) and the
//                  application FSM state enum.

package ShellTypes;

   typedef struct packed {
      logic        valid;
      logic        isWrite;
      logic [31:0] addr;
      logic [63:0] data;
   } SoftRegReq;

   typedef struct packed {
      logic        valid;
      logic [63:0] data;
   } SoftRegResp;

endpackage

package UserRegTypes;

   // Control slots follow the config block: offset = NUM_CFG + <Rel>.
   localparam int unsigned DoorbellRel  = 0;
   localparam int unsigned StatusRel    = 1;
   localparam int unsigned LastRunRel   = 2;
   localparam int unsigned ErrCountRel  = 3;
   localparam int unsigned NumCtrlRegs  = 4;

   typedef enum logic [0:0] {
      StIdle,
      StRun
   } app_state_e;

endpackage

// File: rtl/user_softreg_responder_if.sv
// Soft-register bus between the shell (master) and the user responder (slave).
//   req  : request from the manager (valid, isWrite, addr, data)
//   resp : read response back to the manager (valid, data)

interface user_softreg_responder_if;
   import ShellTypes::*;

   SoftRegReq  req;
   SoftRegResp resp;

   modport master (output req, input  resp);
   modport slave  (input  req, output resp);

endinterface

// File: rtl/user_softreg_responder_rd_pipe.sv
// Two-stage read-response pipeline: a read accepted in cycle N appears on the
// outputs in cycle N+2. Data is forced to zero in any stage whose valid is low.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (flushes both stages)
//   i_valid   : read accepted this cycle
//   i_data    : read data sampled this cycle
//   o_valid   : response valid (registered)
//   o_data    : response data (registered, zero when not valid)

module softreg_rd_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_valid,
   input  logic [63:0] i_data,
   output logic        o_valid,
   output logic [63:0] o_data
);

   logic        r_valid_s1;
   logic        r_valid_s2;
   logic [63:0] r_data_s1;
   logic [63:0] r_data_s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid_s1 <= 1'b0;
         r_valid_s2 <= 1'b0;
         r_data_s1  <= '0;
         r_data_s2  <= '0;
      end else begin
         r_valid_s1 <= i_valid;
         r_data_s1  <= i_valid ? i_data : '0;
         r_valid_s2 <= r_valid_s1;
         r_data_s2  <= r_data_s1;
      end
   end

   assign o_valid = r_valid_s2;
   assign o_data  = r_data_s2;

endmodule

// File: rtl/user_softreg_responder.sv
// User soft-register responder: NUM_CFG R/W config registers, a doorbell that
// starts/aborts an application run, and read-only status/statistics registers.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   softreg        : soft-register bus (slave side)
//   o_cfg_regs     : config register contents, entry i at offset i
//   o_start_pulse  : one-cycle application start strobe
//   o_app_busy     : high while a run is in progress
//   i_app_done     : application completion strobe
//   i_app_status   : live application status word

module user_softreg_responder
   import ShellTypes::*;
   import UserRegTypes::*;
#(
   parameter int unsigned BASE_ADDR = 200,
   parameter int unsigned NUM_CFG   = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   user_softreg_responder_if.slave    softreg,
   output logic [NUM_CFG-1:0][63:0]   o_cfg_regs,
   output logic                       o_start_pulse,
   output logic                       o_app_busy,
   input  logic                       i_app_done,
   input  logic [63:0]                i_app_status
);

   localparam int unsigned CfgIdxW = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;

   app_state_e                 r_state;
   logic                       r_busy;
   logic                       r_start_pulse;
   logic [63:0]                r_cycle_cnt;
   logic [63:0]                r_last_run;
   logic [31:0]                r_run_count;
   logic [31:0]                r_err_count;
   logic [NUM_CFG-1:0][63:0]   r_cfg;

   logic                       w_in_range;
   logic [31:0]                w_off;
   logic [CfgIdxW-1:0]         w_cfg_idx;
   logic                       w_is_cfg;
   logic                       w_is_db;
   logic                       w_is_status;
   logic                       w_is_last_run;
   logic                       w_is_err;
   logic                       w_is_unmapped_hi;
   logic                       w_wr;
   logic                       w_rd;
   logic                       w_start_req;
   logic                       w_abort_req;
   logic                       w_err_evt;
   logic [63:0]                w_rd_data;
   logic                       w_resp_valid;
   logic [63:0]                w_resp_data;

   // Address decode; everything below BASE_ADDR is unmapped and silent.
   assign w_in_range       = softreg.req.addr >= BASE_ADDR;
   assign w_off            = softreg.req.addr - BASE_ADDR;
   assign w_cfg_idx        = w_off[CfgIdxW-1:0];
   assign w_is_cfg         = w_in_range && (w_off < NUM_CFG);
   assign w_is_db          = w_in_range && (w_off == NUM_CFG + DoorbellRel);
   assign w_is_status      = w_in_range && (w_off == NUM_CFG + StatusRel);
   assign w_is_last_run    = w_in_range && (w_off == NUM_CFG + LastRunRel);
   assign w_is_err         = w_in_range && (w_off == NUM_CFG + ErrCountRel);
   assign w_is_unmapped_hi = w_in_range && (w_off >= NUM_CFG + NumCtrlRegs);

   assign w_wr        = softreg.req.valid && softreg.req.isWrite;
   assign w_rd        = softreg.req.valid && !softreg.req.isWrite;
   assign w_start_req = w_wr && w_is_db && softreg.req.data[0];
   assign w_abort_req = w_wr && w_is_db && softreg.req.data[1];

   assign w_err_evt = w_wr && (((w_is_db && softreg.req.data[0]) && (r_state == StRun)) ||
                               (w_is_cfg && (r_state == StRun)) ||
                               w_is_status || w_is_last_run || w_is_err ||
                               w_is_unmapped_hi);

   // Read mux over current register state; unmapped addresses read as zero.
   always_comb begin
      w_rd_data = '0;
      if (w_is_cfg) begin
         w_rd_data = r_cfg[w_cfg_idx];
      end else if (w_is_db) begin
         w_rd_data = {r_busy, 31'b0, r_run_count};
      end else if (w_is_status) begin
         w_rd_data = i_app_status;
      end else if (w_is_last_run) begin
         w_rd_data = r_last_run;
      end else if (w_is_err) begin
         w_rd_data = {32'b0, r_err_count};
      end
   end

   // Config writes are dropped while a run is in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cfg       <= '0;
         r_err_count <= '0;
      end else begin
         if (w_wr && w_is_cfg && (r_state == StIdle)) begin
            r_cfg[w_cfg_idx] <= softreg.req.data;
         end
         if (w_err_evt && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 32'd1;
         end
      end
   end

   // Application run FSM with registered strobe/busy outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= StIdle;
         r_busy        <= 1'b0;
         r_start_pulse <= 1'b0;
         r_cycle_cnt   <= '0;
         r_last_run    <= '0;
         r_run_count   <= '0;
      end else begin
         r_start_pulse <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_start_req) begin
                  r_state       <= StRun;
                  r_busy        <= 1'b1;
                  r_start_pulse <= 1'b1;
                  r_cycle_cnt   <= '0;
               end
            end
            StRun: begin
               if (r_cycle_cnt != '1) begin
                  r_cycle_cnt <= r_cycle_cnt + 64'd1;
               end
               // Abort wins over a simultaneous completion.
               if (w_abort_req) begin
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
               end else if (i_app_done) begin
                  r_last_run  <= r_cycle_cnt;
                  r_run_count <= r_run_count + 32'd1;
                  r_state     <= StIdle;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   softreg_rd_pipe u_rd_pipe (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_rd),
      .i_data  (w_rd_data),
      .o_valid (w_resp_valid),
      .o_data  (w_resp_data)
   );

   assign softreg.resp.valid = w_resp_valid;
   assign softreg.resp.data  = w_resp_data;

   assign o_cfg_regs    = r_cfg;
   assign o_start_pulse = r_start_pulse;
   assign o_app_busy    = r_busy;

endmodule

// File: tb/tb_user_softreg_responder.sv
// Directed bench for user_softreg_responder with hand-computed expectations.

module tb_user_softreg_responder;

   localparam int unsigned NumCfg = 8;

   logic                     clk;
   logic                     rst;
   logic [NumCfg-1:0][63:0]  cfg_regs;
   logic                     start_pulse;
   logic                     app_busy;
   logic                     app_done;
   logic [63:0]              app_status;

   int n_checks = 0;
   int n_fail   = 0;
   int start_cnt = 0;

   user_softreg_responder_if sr_if ();

   user_softreg_responder #(
      .BASE_ADDR (200),
      .NUM_CFG   (NumCfg)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .softreg       (sr_if.slave),
      .o_cfg_regs    (cfg_regs),
      .o_start_pulse (start_pulse),
      .o_app_busy    (app_busy),
      .i_app_done    (app_done),
      .i_app_status  (app_status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (start_pulse) start_cnt <= start_cnt + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: sim time %0t reached without finishing, required finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic w, input logic [31:0] a,
                        input logic [63:0] d);
      sr_if.req.valid   = v;
      sr_if.req.isWrite = w;
      sr_if.req.addr    = a;
      sr_if.req.data    = d;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'd0, 64'd0);
   endtask

   // Issue a read in the current cycle N; return in cycle N+2 after checking.
   task automatic read_chk(input string tag, input logic [31:0] a, input logic [63:0] exp);
      drive(1'b1, 1'b0, a, 64'd0);
      tick();
      idle();
      check_eq({tag, "_n1_valid"}, 64'(sr_if.resp.valid), 64'd0);
      tick();
      check_eq({tag, "_valid"}, 64'(sr_if.resp.valid), 64'd1);
      check_eq({tag, "_data"}, sr_if.resp.data, exp);
   endtask

   initial begin
      rst        = 1'b1;
      app_done   = 1'b0;
      app_status = 64'h0;
      idle();
      tick(); tick(); tick();

      // Reset state
      check_eq("rst_resp_valid", 64'(sr_if.resp.valid), 64'd0);
      check_eq("rst_resp_data", sr_if.resp.data, 64'd0);
      check_eq("rst_start", 64'(start_pulse), 64'd0);
      check_eq("rst_busy", 64'(app_busy), 64'd0);
      check_eq("rst_cfg3", cfg_regs[3], 64'd0);
      rst = 1'b0;
      tick();

      // cfg write visible next cycle, then read back with 2-cycle latency
      drive(1'b1, 1'b1, 32'd203, 64'hA5);
      tick();
      idle();
      check_eq("cfg3_after_wr", cfg_regs[3], 64'hA5);
      read_chk("rd203", 32'd203, 64'hA5);
      tick();
      check_eq("rd203_n3_valid", 64'(sr_if.resp.valid), 64'd0);
      check_eq("rd203_n3_data", sr_if.resp.data, 64'd0);

      // Back-to-back reads 200, 201, 250
      drive(1'b1, 1'b1, 32'd200, 64'h11);
      tick();
      drive(1'b1, 1'b1, 32'd201, 64'h22);
      tick();
      drive(1'b1, 1'b0, 32'd200, 64'd0);
      tick();
      drive(1'b1, 1'b0, 32'd201, 64'd0);
      check_eq("b2b_n1_valid", 64'(sr_if.resp.valid), 64'd0);
      tick();
      drive(1'b1, 1'b0, 32'd250, 64'd0);
      check_eq("b2b_r0_valid", 64'(sr_if.resp.valid), 64'd1);
      check_eq("b2b_r0_data", sr_if.resp.data, 64'h11);
      tick();
      idle();
      check_eq("b2b_r1_valid", 64'(sr_if.resp.valid), 64'd1);
      check_eq("b2b_r1_data", sr_if.resp.data, 64'h22);
      tick();
      check_eq("b2b_r2_valid", 64'(sr_if.resp.valid), 64'd1);
      check_eq("b2b_r2_data", sr_if.resp.data, 64'd0);
      tick();
      check_eq("b2b_end_valid", 64'(sr_if.resp.valid), 64'd0);

      // Below-base read and live status read
      read_chk("rd_below", 32'd100, 64'd0);
      app_status = 64'hDEAD_BEEF_0123_4567;
      read_chk("rd_status", 32'd209, 64'hDEAD_BEEF_0123_4567);

      // Run: start, done 10 cycles after the start pulse
      drive(1'b1, 1'b1, 32'd208, 64'd1);
      tick();
      idle();
      check_eq("run1_start", 64'(start_pulse), 64'd1);
      check_eq("run1_busy", 64'(app_busy), 64'd1);
      tick();
      check_eq("run1_start_once", 64'(start_pulse), 64'd0);
      for (int i = 0; i < 9; i++) tick();
      app_done = 1'b1;
      tick();
      app_done = 1'b0;
      check_eq("run1_busy_after_done", 64'(app_busy), 64'd0);
      read_chk("run1_last", 32'd210, 64'd10);
      read_chk("run1_db", 32'd208, 64'd1);
      check_eq("run1_start_cnt", 64'(start_cnt), 64'd1);

      // Errors during RUN: cfg write dropped, second start rejected
      drive(1'b1, 1'b1, 32'd208, 64'd1);
      tick();
      drive(1'b1, 1'b1, 32'd200, 64'hFF);
      tick();
      drive(1'b1, 1'b1, 32'd208, 64'd1);
      tick();
      idle();
      check_eq("run2_cfg0_kept", cfg_regs[0], 64'h11);
      check_eq("run2_busy", 64'(app_busy), 64'd1);
      read_chk("run2_db_busy", 32'd208, 64'h8000_0000_0000_0001);
      read_chk("run2_err", 32'd211, 64'd2);
      check_eq("run2_start_cnt", 64'(start_cnt), 64'd2);

      // Abort with simultaneous app_done: abort wins
      drive(1'b1, 1'b1, 32'd208, 64'd2);
      app_done = 1'b1;
      tick();
      idle();
      app_done = 1'b0;
      check_eq("abort_busy", 64'(app_busy), 64'd0);
      read_chk("abort_db", 32'd208, 64'd1);
      read_chk("abort_last", 32'd210, 64'd10);

      // RO/unmapped writes count; below-base, no-op doorbell, idle done do not
      drive(1'b1, 1'b1, 32'd209, 64'd5);
      tick();
      drive(1'b1, 1'b1, 32'd250, 64'd5);
      tick();
      drive(1'b1, 1'b1, 32'd100, 64'd5);
      tick();
      drive(1'b1, 1'b1, 32'd208, 64'd0);
      tick();
      idle();
      app_done = 1'b1;
      tick();
      app_done = 1'b0;
      check_eq("noop_busy", 64'(app_busy), 64'd0);
      read_chk("err4", 32'd211, 64'd4);

      // Doorbell with both bits set in IDLE starts only
      drive(1'b1, 1'b1, 32'd208, 64'd3);
      tick();
      idle();
      check_eq("both_start", 64'(start_pulse), 64'd1);
      check_eq("both_busy", 64'(app_busy), 64'd1);

      // Reset mid-RUN with a read in flight
      drive(1'b1, 1'b0, 32'd200, 64'd0);
      tick();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("rstrd_valid", 64'(sr_if.resp.valid), 64'd0);
      check_eq("rstrd_data", sr_if.resp.data, 64'd0);
      check_eq("rstrd_busy", 64'(app_busy), 64'd0);
      check_eq("rstrd_start", 64'(start_pulse), 64'd0);
      check_eq("rstrd_cfg0", cfg_regs[0], 64'd0);
      check_eq("rstrd_cfg3", cfg_regs[3], 64'd0);
      tick();
      check_eq("rstrd_n3_valid", 64'(sr_if.resp.valid), 64'd0);
      check_eq("rstrd_n3_start", 64'(start_pulse), 64'd0);
      read_chk("rstrd_err", 32'd211, 64'd0);
      read_chk("rstrd_db", 32'd208, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
